// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: state encoding, data widths
// and the byte-enable merge used by the storage array.
package dm_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_RESP = ST_RESP
    } state_e;

    // Replace only the bytes of old_w whose enable bit is set.
    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word array with per-byte write enables, one-cycle whole-array clear and a
// registered read port that only updates when a read is requested.
module dm_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Storage update, clear and registered read.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WORD_W{1'b0}};
            end
            r_rdata <= {WORD_W{1'b0}};
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= be_merge(r_mem[i_waddr], i_wdata, i_be);
            end
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then presents read data or a write acknowledge until the initiator takes it.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    state_e            r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [ADDR_W-1:0] r_idx;

    logic [31:0]       w_off;
    logic              w_oor;
    logic              w_accept;
    logic              w_enter_resp;
    logic [WORD_W-1:0] w_arr_rdata;

    // Wrap-around below BASE_ADDR shows up as req_addr < BASE_ADDR.
    assign w_off        = req_addr - BASE_ADDR;
    assign w_oor        = (req_addr < BASE_ADDR) || ((w_off >> (ADDR_W + 2)) != 32'd0);
    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_enter_resp = (r_state == S_BUSY) && (r_cnt == 4'd0);

    dm_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (clk),
        .i_clr   (reset),
        .i_we    (w_accept && req_write && !w_oor),
        .i_waddr (w_off[ADDR_W+1:2]),
        .i_wdata (req_wdata),
        .i_be    (req_be),
        .i_re    (w_enter_resp && !r_write && !r_err),
        .i_raddr (r_idx),
        .o_rdata (w_arr_rdata)
    );

    // Request capture, wait-state counting and response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_err   <= w_oor;
                        r_idx   <= w_off[ADDR_W+1:2];
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_write && !r_err) ? w_arr_rdata : {WORD_W{1'b0}};

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the data-memory interface that the MIPS core drives as initiator.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns read data or a write acknowledge over a valid/ready response channel.
- Replaces the zero-wait `dm` when the core is moved to a multi-cycle/stalling datapath; also serves as the bench model for stall testing.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] are ignored.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; be[0] selects bits [7:0].
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  address out of range.

Behaviour:
- Reset (synchronous, active-high):
  - State becomes IDLE, the latency counter is cleared, and every array word is cleared to 0.
  - Outputs after the reset edge: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Reset while BUSY or RESP aborts the transaction. No response is produced and any committed store is lost, because the array is cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid, go to BUSY and load the counter with LATENCY-1.
  - BUSY: req_ready=0. Decrement the counter each cycle; when it reaches 0, go to RESP.
  - RESP: resp_valid=1. When resp_ready=1, return to IDLE.
- A request is accepted only in the cycle where req_valid && req_ready. The address, write flag, data and enables are captured into internal registers; request inputs are don't-care afterwards.
- Latency: a request accepted at edge N raises resp_valid after edge N+LATENCY.
- resp_valid, resp_rdata and resp_err hold stable while resp_ready=0; there is no timeout.
- req_ready=0 throughout BUSY and RESP. A new request can be accepted no earlier than the cycle after the response handshake, so there is no overlap or pipelining.
- Address decode:
  - word index = (req_addr - BASE_ADDR) >> 2.
  - The address is out of range if req_addr < BASE_ADDR or the index ≥ 2^ADDR_W. Subtraction is 32-bit unsigned and wrap-around is treated as out of range.
  - Out of range: resp_err=1, resp_rdata=0, no array write.
- Stores:
  - Committed on the acceptance edge, per byte where req_be=1.
  - req_be=4'b0000 is a legal no-op store that still produces an acknowledge (resp_err=0).
- Loads:
  - resp_rdata is the array word sampled on the edge entering RESP.
  - A load accepted after a store's response observes the stored value (read-after-write ordering).
- Outputs are registered; no combinational path from request inputs to response outputs. req_ready is decoded from state only.

Decomposition:
- Shared package dm_pkg:
  - state encoding localparams: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2;
  - WORD_W=32 and BE_W=4.
- One natural sub-module, dm_array: a 2^ADDR_W × 32 byte-enable write array with synchronous clear and a registered read port. The FSM, decode and counter stay in dm_responder.

Test Plan:
- Reset then idle: req_ready=1, resp_valid=0, resp_rdata=0 on the cycle after the reset edge; a load from 0x0000_0010 returns 0x0000_0000.
- Store/load, LATENCY=2: store 0xDEADBEEF, be=4'hF to 0x0000_0020 accepted at edge N → resp_valid after edge N+2 with resp_err=0. A load from 0x0000_0022 then returns 0xDEADBEEF.
- Byte enables: word 0x0000_0040 holds 0x11223344; store 0xAABBCCDD with be=4'b0101 → a subsequent load returns 0x11BB33DD.
- Backpressure: hold resp_ready=0 for 5 cycles during a load response → resp_valid and resp_rdata are constant; req_valid asserted meanwhile is not accepted (req_ready=0) until one cycle after resp_ready=1.
- Out of range, ADDR_W=10, BASE_ADDR=0: store to 0x0000_1000 → resp_err=1, resp_rdata=0. A load from 0x0000_0000 is unchanged afterwards.
- Reset mid-operation: assert reset during BUSY of a load → no resp_valid is ever issued for it. FSM returns to IDLE with req_ready=1, and previously written words read back as 0.
